uart_tx_dev: RTL and testbench
==============================

# uart_tx_dev

Memory-mapped serial transmitter peripheral on the processor's shared data bus. It is a bus responder alongside the LED, HEX, switch, key and timer devices, and its `dataBusOut` is OR-combined into `dataBus`. The CPU writes bytes into an internal FIFO, and the block shifts them out on a single `tx` pin as 8N1 frames. Status and overrun reporting go through a control register.

## Interface
Parameters:
- `BITS`, 32: bus data/address width.
- `BASE`, 32'hF0000030: data register address.
- `CTRL_BASE`, 32'hF0000130: control/status register address.
- `CLKS_PER_BIT`, 217: clocks per serial bit (25 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `we` in 1: bus write strobe.
- `re` in 1: bus read strobe.
- `memAddr` in BITS: bus address.
- `dataBusIn` in BITS: bus write data.
- `dataBusOut` out BITS: read data; all zeros unless `re` is high and `memAddr` matches.
- `tx` out 1: serial line; idles high.

## Operation
- Writes to `BASE`:
  - `we` high with `memAddr == BASE` pushes `dataBusIn[7:0]`.
  - The push is accepted iff the FIFO is not full at that edge, even if a pop happens in the same cycle.
  - A rejected push sets sticky `ovr`.
- Reads of `BASE`: `dataBusOut` = zero-extended FIFO occupancy count (0..FIFO_DEPTH).
- Reads of `CTRL_BASE`: `dataBusOut` = {zeros, ovr[2], busy[1], ready[0]}.
  - ready = FIFO not full.
  - busy = FSM not in IDLE or FIFO not empty.
- Writes to `CTRL_BASE`: writing 1 to bit 2 clears `ovr`; all other bits are ignored.
  - If a clear and an overrun occur in the same cycle, the overrun wins (`ovr` = 1).
- Read path is combinational: `re` plus address match gives the value in the same cycle. Reads have no side effects.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. When the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. In the last STOP cycle:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1, wraps, and is cleared on every state entry. Width is $clog2(CLKS_PER_BIT).
- FIFO count updates with push only (+1), pop only (−1), push and pop together (unchanged). Pointers wrap modulo FIFO_DEPTH.
- Reset (asynchronous, mid-frame included) produces:
  - FSM in IDLE, `tx`=1;
  - FIFO emptied (pointers and count = 0);
  - `ovr`=0, bit timer and bit index = 0.
  - Any frame in progress is truncated.

## Timing
- A push at edge N into an empty FIFO with FSM in IDLE:
  - edge N+1: pop;
  - `tx` falls after edge N+1;
  - frame lasts exactly 10·CLKS_PER_BIT cycles.
- Back-to-back bytes have no idle cycles between the stop bit and the next start bit.
- The FIFO count seen on a read reflects all pushes and pops up to and including the previous edge.
- `tx` is registered, so it is glitch-free.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` {IDLE, START, DATA, STOP};
  - register offset constants;
  - status bit-index constants (READY=0, BUSY=1, OVR=2).
- Sub-module `uart_tx_fifo`: synchronous byte FIFO with push/pop/full/empty/count and async active-low reset.
- Top level holds the bus decode, the status/`ovr` logic and the transmit FSM.

## Test plan
- Single byte: reset, write 0xA5 to BASE, sample `tx` mid-bit every CLKS_PER_BIT → expect 0,1,0,1,0,0,1,0,1,1. Then read CTRL_BASE → busy=0, ready=1.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles → three contiguous frames, 30·CLKS_PER_BIT cycles total, no high gap beyond the stop bits.
- Overflow:
  - with FSM busy, write 9 bytes (FIFO_DEPTH=8) → 9th dropped; CTRL read = 0b110, BASE read = 8;
  - write 0x4 to CTRL_BASE → ovr cleared.
- Full plus pop in the same cycle: fill the FIFO and time a write to the STOP→START pop edge → write rejected, `ovr`=1, count = 7.
- Bus isolation:
  - reads/writes to other addresses (e.g. 32'hF0000004) → `dataBusOut`=0 and no FIFO change;
  - `re` low with matching address → `dataBusOut`=0.
- Reset mid-DATA: assert `reset` low during bit 3 → `tx`=1 immediately, count=0, ovr=0. After release, a new write transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_pkg;

  // Transmit state machine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Register offsets relative to the data register address
  localparam logic [31:0] UART_DATA_OFS = 32'h0000_0000;
  localparam logic [31:0] UART_CTRL_OFS = 32'h0000_0100;

  // Status register bit positions
  localparam int unsigned STAT_READY = 0;
  localparam int unsigned STAT_BUSY  = 1;
  localparam int unsigned STAT_OVR   = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy count and async active-low reset.
// A push is accepted only when not full, regardless of a same-cycle pop.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 serial transmitter: bus decode, status/overrun
// register, byte FIFO and transmit state machine.
module uart_tx_dev
  import uart_pkg::*;
#(
  parameter int unsigned    BITS         = 32,
  parameter logic [BITS-1:0] BASE        = 32'hF0000030,
  parameter logic [BITS-1:0] CTRL_BASE   = 32'hF0000130,
  parameter int unsigned    CLKS_PER_BIT = 217,
  parameter int unsigned    FIFO_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut,
  output logic            tx
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t r_state;
  logic [TW-1:0]  r_timer;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic           r_ovr;

  logic           w_data_hit;
  logic           w_ctrl_hit;
  logic           w_push_req;
  logic           w_pop;
  logic           w_bit_end;
  logic           w_full;
  logic           w_empty;
  logic           w_busy;
  logic [7:0]     w_fifo_data;
  logic [CW-1:0]  w_count;
  logic           w_unused_data;

  assign w_data_hit    = (memAddr == BASE);
  assign w_ctrl_hit    = (memAddr == CTRL_BASE);
  assign w_push_req    = we && w_data_hit;
  assign w_bit_end     = (r_timer == TW'(CLKS_PER_BIT - 1));
  assign w_busy        = (r_state != IDLE) || !w_empty;
  assign w_unused_data = ^dataBusIn[BITS-1:8];
  assign tx            = r_tx;

  // Pop when idle, or on the last stop-bit cycle so frames run back to back
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_data  (dataBusIn[7:0]),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Combinational read mux; zero unless a register is addressed and read
  always_comb begin
    dataBusOut = '0;
    if (re && w_data_hit) begin
      dataBusOut = BITS'(w_count);
    end else if (re && w_ctrl_hit) begin
      dataBusOut[STAT_READY] = !w_full;
      dataBusOut[STAT_BUSY]  = w_busy;
      dataBusOut[STAT_OVR]   = r_ovr;
    end
  end

  // Sticky overrun flag; a same-cycle overrun beats a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovr <= 1'b0;
    end else if (w_push_req && w_full) begin
      r_ovr <= 1'b1;
    end else if (we && w_ctrl_hit && dataBusIn[STAT_OVR]) begin
      r_ovr <= 1'b0;
    end
  end

  // Transmit FSM; tx is computed one cycle ahead so the pin is a flop output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          r_tx    <= 1'b1;
          if (w_pop) begin
            r_shift <= w_fifo_data;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (w_pop) begin
              r_shift <= w_fifo_data;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_timer <= '0;
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed testbench for uart_tx_dev with hand-computed expectations.
module tb_uart_tx_dev;

  localparam int unsigned C         = 16;
  localparam logic [31:0] BASE      = 32'hF0000030;
  localparam logic [31:0] CTRL_BASE = 32'hF0000130;
  localparam logic [31:0] OTHER     = 32'hF0000004;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        re;
  logic [31:0] memAddr;
  logic [31:0] dataBusIn;
  logic [31:0] dataBusOut;
  logic        tx;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned cyc     = 0;

  uart_tx_dev #(
    .BITS         (32),
    .BASE         (BASE),
    .CTRL_BASE    (CTRL_BASE),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .re         (re),
    .memAddr    (memAddr),
    .dataBusIn  (dataBusIn),
    .dataBusOut (dataBusOut),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; memAddr = a; dataBusIn = d;
    @(negedge clk);
    we = 1'b0; memAddr = '0; dataBusIn = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    re = 1'b1; memAddr = a;
    #1;
    v = dataBusOut;
    re = 1'b0; memAddr = '0;
  endtask

  // Sample each of the 10 bits of a frame starting at edge f, mid-bit
  task automatic check_frame(input string tag, input int unsigned f, input logic [7:0] b);
    logic expb;
    for (int k = 0; k < 10; k++) begin
      wait_until(f + C/2 + k*C);
      if (k == 0)      expb = 1'b0;
      else if (k == 9) expb = 1'b1;
      else             expb = b[k-1];
      chk($sformatf("%s_bit%0d", tag, k), {31'd0, tx}, {31'd0, expb});
    end
  endtask

  initial begin
    logic [31:0] v;
    int unsigned f;
    int unsigned p;

    reset = 1'b0; we = 1'b0; re = 1'b0; memAddr = '0; dataBusIn = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    bus_read(CTRL_BASE, v); chk("rst_ctrl", v, 32'h1);
    bus_read(BASE, v);      chk("rst_count", v, 32'h0);

    // Bus isolation
    bus_write(OTHER, 32'h77);
    bus_write(CTRL_BASE, 32'hFF);
    bus_read(BASE, v);  chk("iso_count", v, 32'h0);
    bus_read(OTHER, v); chk("iso_other_rd", v, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("iso_tx_idle", {31'd0, tx}, 32'd1);
    bus_read(CTRL_BASE, v); chk("iso_ctrl", v, 32'h1);

    // Single byte 0xA5
    bus_write(BASE, 32'hA5);
    f = cyc + 1;
    check_frame("single", f, 8'hA5);
    wait_until(f + 10*C + 2);
    bus_read(CTRL_BASE, v); chk("single_ctrl_done", v, 32'h1);
    bus_read(BASE, v);      chk("single_count_done", v, 32'h0);

    // Back-to-back writes on consecutive cycles
    @(negedge clk);
    we = 1'b1; memAddr = BASE; dataBusIn = 32'h00;
    @(negedge clk);
    dataBusIn = 32'hFF;
    @(negedge clk);
    dataBusIn = 32'h55;
    @(negedge clk);
    we = 1'b0; memAddr = '0; dataBusIn = '0;
    f = cyc - 1;
    check_frame("b2b0", f,          8'h00);
    check_frame("b2b1", f + 10*C,   8'hFF);
    check_frame("b2b2", f + 20*C,   8'h55);
    bus_read(CTRL_BASE, v); chk("b2b_ctrl_busy", v, 32'h3);
    wait_until(f + 30*C + 1);
    chk("b2b_tx_idle", {31'd0, tx}, 32'd1);
    bus_read(CTRL_BASE, v); chk("b2b_ctrl_done", v, 32'h1);

    // Overflow while transmitting
    bus_write(BASE, 32'h11);
    f = cyc + 1;
    for (int i = 0; i < 9; i++) bus_write(BASE, 32'h80 + i);
    bus_read(CTRL_BASE, v); chk("ovf_ctrl", v, 32'h6);
    bus_read(BASE, v);      chk("ovf_count", v, 32'h8);
    @(negedge clk);
    memAddr = BASE; re = 1'b0;
    #1;
    chk("re_low", dataBusOut, 32'h0);
    memAddr = '0;
    bus_write(CTRL_BASE, 32'h4);
    bus_read(CTRL_BASE, v); chk("ovr_clear", v, 32'h2);
    bus_read(BASE, v);      chk("ovr_clear_count", v, 32'h8);

    // Write on the STOP->START pop edge with the FIFO full
    p = f + 10*C;
    while (cyc < p - 1) begin
      @(posedge clk);
      #1;
    end
    we = 1'b1; memAddr = BASE; dataBusIn = 32'hEE;
    @(posedge clk);
    #1;
    we = 1'b0; memAddr = '0; dataBusIn = '0;
    chk("fullpop_tx_start", {31'd0, tx}, 32'd0);
    bus_read(CTRL_BASE, v); chk("fullpop_ctrl", v, 32'h7);
    bus_read(BASE, v);      chk("fullpop_count", v, 32'h7);

    // Reset during data bit 3 of byte 0x80
    wait_until(p + 4*C + C/2);
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    re = 1'b1; memAddr = BASE;
    #1;
    chk("midrst_count", dataBusOut, 32'h0);
    memAddr = CTRL_BASE;
    #1;
    chk("midrst_ctrl", dataBusOut, 32'h1);
    re = 1'b0; memAddr = '0;
    @(negedge clk);
    reset = 1'b1;

    // Normal transmit after reset release
    bus_write(BASE, 32'h3C);
    f = cyc + 1;
    check_frame("post", f, 8'h3C);
    wait_until(f + 10*C + 1);
    chk("post_tx_idle", {31'd0, tx}, 32'd1);
    bus_read(CTRL_BASE, v); chk("post_ctrl", v, 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
